// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//   Shared pipeline definitions for the MEM stage and its neighbours.
//   - DATA_W / REG_W : default datapath and register-index widths
//   - ctrl_t         : EX/MEM control bundle, also used by ID/EX and the
//                      forwarding unit
//   - mem_state_t    : state encoding of the data-memory access FSM
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
//   Counts the cycles a data-memory request has been waiting for its ack.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     start    : first request cycle went unacknowledged; counter loads 1
//     ack      : memory acknowledged this cycle; timer goes idle
//     expire   : still no ack and the counter has reached TIMEOUT-1, so this
//                is the last request cycle that will be offered
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic expire
);

  logic [7:0] cnt;
  logic       running;

  assign expire = running & ~ack & (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 8'd0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= 8'd1;
      running <= 1'b1;
    end else if (running) begin
      if (ack || expire) begin
        cnt     <= 8'd0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   MEM stage of the 5-stage MIPS pipeline: EX/MEM register, single-
//   outstanding data-memory port, MEM/WB register and forwarding taps.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     ex_*                         instruction leaving EX (ex_valid=0: bubble)
//     mem_stall                    freeze everything upstream of EX/MEM
//     ex_mem_data3/desreg/regwrite EX/MEM forwarding taps
//     dmem_req/we/addr/wdata       memory request
//     dmem_rdata/ack               memory response
//     mem_wb_data3/desreg/regwrite write-back value and control
//     bus_err                      sticky timeout / misalignment flag
//     dbg_state                    current access FSM state
//
//   Memory handshake: dmem_req is held high with addr/wdata/we stable (EX/MEM
//   is frozen by mem_stall) until the cycle in which dmem_ack is high; that
//   cycle completes the access and rdata is taken from it. One request is
//   outstanding at most. If no ack arrives within TIMEOUT request cycles the
//   request is withdrawn for one ABORT cycle and the op retires as a bubble.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W  = mem_stage_pkg::DATA_W,
  parameter int REG_W   = mem_stage_pkg::REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [DATA_W-1:0]         ex_aluresult,
  input  logic [DATA_W-1:0]         ex_rtresult,
  input  logic [REG_W-1:0]          ex_desreg,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic                      ex_memwrite,
  input  logic                      ex_memtoreg,
  output logic                      mem_stall,
  output logic [DATA_W-1:0]         ex_mem_data3,
  output logic [REG_W-1:0]          ex_mem_desreg,
  output logic                      ex_mem_regwrite,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_W-1:0]         dmem_addr,
  output logic [DATA_W-1:0]         dmem_wdata,
  input  logic [DATA_W-1:0]         dmem_rdata,
  input  logic                      dmem_ack,
  output logic [DATA_W-1:0]         mem_wb_data3,
  output logic [REG_W-1:0]          mem_wb_desreg,
  output logic                      mem_wb_regwrite,
  output logic                      bus_err,
  output mem_stage_pkg::mem_state_t dbg_state
);

  import mem_stage_pkg::*;

  // EX/MEM register
  ctrl_t              ex_ctrl;
  ctrl_t              exm_ctrl;
  logic [DATA_W-1:0]  exm_aluresult;
  logic [DATA_W-1:0]  exm_rtresult;
  logic [REG_W-1:0]   exm_desreg;

  // MEM/WB register
  logic [DATA_W-1:0]  mwb_data3;
  logic [REG_W-1:0]   mwb_desreg;
  logic               mwb_regwrite;

  mem_state_t state_q, state_d;
  logic       memop, misaligned, aligned_op;
  logic       wait_start, expire, retire, err_set;
  logic       bus_err_q;

  // A bubble carries no side effects: every control bit is cleared.
  always_comb begin
    ex_ctrl = '0;
    if (ex_valid) begin
      ex_ctrl.regwrite = ex_regwrite;
      ex_ctrl.memread  = ex_memread;
      ex_ctrl.memwrite = ex_memwrite;
      ex_ctrl.memtoreg = ex_memtoreg;
    end
  end

  assign memop      = exm_ctrl.memread | exm_ctrl.memwrite;
  assign misaligned = exm_aluresult[1:0] != 2'b00;
  assign aligned_op = memop & ~misaligned;

  assign dmem_req   = aligned_op & (state_q != S_ABORT);
  assign dmem_we    = exm_ctrl.memwrite;
  assign dmem_addr  = exm_aluresult;
  assign dmem_wdata = exm_rtresult;
  assign mem_stall  = dmem_req & ~dmem_ack;

  // Only a first-cycle miss arms the timer; WAIT already has it running.
  assign wait_start = (state_q == S_IDLE) & dmem_req & ~dmem_ack;

  // The op in EX/MEM leaves with its results only if it actually finished:
  // aborted and misaligned accesses leave as bubbles.
  assign retire  = ~mem_stall & (state_q != S_ABORT) & ~(memop & misaligned);
  assign err_set = (state_q == S_ABORT) | (memop & misaligned);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (wait_start),
    .ack    (dmem_ack),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (wait_start) state_d = S_WAIT;
      S_WAIT: begin
        if (dmem_ack)    state_d = S_IDLE;
        else if (expire) state_d = S_ABORT;
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_ctrl      <= '0;
      exm_aluresult <= '0;
      exm_rtresult  <= '0;
      exm_desreg    <= '0;
    end else if (!mem_stall) begin
      exm_ctrl      <= ex_ctrl;
      exm_aluresult <= ex_aluresult;
      exm_rtresult  <= ex_rtresult;
      exm_desreg    <= ex_desreg;
    end
  end

  // MEM/WB: a non-retiring cycle inserts a bubble but keeps data/desreg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mwb_data3    <= '0;
      mwb_desreg   <= '0;
      mwb_regwrite <= 1'b0;
    end else if (retire) begin
      mwb_regwrite <= exm_ctrl.regwrite;
      mwb_desreg   <= exm_desreg;
      mwb_data3    <= exm_ctrl.memtoreg ? dmem_rdata : exm_aluresult;
    end else begin
      mwb_regwrite <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bus_err_q <= 1'b0;
    else if (err_set) bus_err_q <= 1'b1;
  end

  assign ex_mem_data3    = exm_aluresult;
  assign ex_mem_desreg   = exm_desreg;
  assign ex_mem_regwrite = exm_ctrl.regwrite;
  assign mem_wb_data3    = mwb_data3;
  assign mem_wb_desreg   = mwb_desreg;
  assign mem_wb_regwrite = mwb_regwrite;
  assign bus_err         = bus_err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Directed scenarios for reset, ALU pass-through, zero-wait load, waited
//   store, timeout, reset mid-wait and misalignment, followed by a random
//   instruction stream scored against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  import mem_stage_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk, rst;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [DW-1:0] ex_aluresult, ex_rtresult;
  logic [RW-1:0] ex_desreg;
  logic          mem_stall, ex_mem_regwrite, dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] ex_mem_data3, dmem_addr, dmem_wdata, dmem_rdata, mem_wb_data3;
  logic [RW-1:0] ex_mem_desreg, mem_wb_desreg;
  logic          mem_wb_regwrite, bus_err;
  mem_state_t    dbg_state;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected write-backs {desreg, data3} in retirement order
  logic [RW+DW-1:0] exp_q[$];
  // wait cycles the responder inserts before ack, one per aligned memory op
  int               wait_q[$];
  logic [DW-1:0]    model_mem [logic [DW-1:0]];
  logic [DW-1:0]    resp_mem  [logic [DW-1:0]];
  logic             exp_err   = 1'b0;
  bit               auto_resp = 1'b0;
  bit               sb_on     = 1'b0;

  mem_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_aluresult    (ex_aluresult),
    .ex_rtresult     (ex_rtresult),
    .ex_desreg       (ex_desreg),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .ex_memwrite     (ex_memwrite),
    .ex_memtoreg     (ex_memtoreg),
    .mem_stall       (mem_stall),
    .ex_mem_data3    (ex_mem_data3),
    .ex_mem_desreg   (ex_mem_desreg),
    .ex_mem_regwrite (ex_mem_regwrite),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .mem_wb_data3    (mem_wb_data3),
    .mem_wb_desreg   (mem_wb_desreg),
    .mem_wb_regwrite (mem_wb_regwrite),
    .bus_err         (bus_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_default(input logic [DW-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ex(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                        input logic [RW-1:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic mtr);
    ex_valid = v; ex_aluresult = alu; ex_rtresult = rt; ex_desreg = rd;
    ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw; ex_memtoreg = mtr;
  endtask

  task automatic bubble();
    set_ex(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it until the stage accepts it.
  task automatic issue(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                       input logic [RW-1:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic mtr);
    bit done;
    done = 1'b0;
    set_ex(v, alu, rt, rd, rw, mr, mw, mtr);
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      #2;
      if (!mem_stall) done = 1'b1;
    end
    if (!done) chk("accept_bound", 64'(mem_stall), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder (random phase) ----------------
  initial begin : responder
    int            req_cnt;
    int            cur_w;
    logic [DW-1:0] h_addr, h_wdata;
    logic          h_we;
    req_cnt = 0; cur_w = 0; h_addr = '0; h_wdata = '0; h_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_resp || rst) begin
        req_cnt = 0;
      end else if (dmem_req) begin
        if (req_cnt == 0) begin
          if (wait_q.size() != 0) cur_w = wait_q.pop_front();
          else begin
            chk("req_unexpected", 64'(dmem_req), 64'd0);
            cur_w = 0;
          end
          h_addr = dmem_addr; h_wdata = dmem_wdata; h_we = dmem_we;
        end else begin
          chk("hold_addr", 64'(dmem_addr), 64'(h_addr));
          chk("hold_wdata", 64'(dmem_wdata), 64'(h_wdata));
          chk("hold_we", 64'(dmem_we), 64'(h_we));
        end
        if (req_cnt == cur_w) begin
          dmem_ack   = 1'b1;
          dmem_rdata = resp_mem.exists(dmem_addr) ? resp_mem[dmem_addr] : mem_default(dmem_addr);
          if (dmem_we) resp_mem[dmem_addr] = dmem_wdata;
          req_cnt = 0;
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          req_cnt++;
          if (req_cnt == TO) req_cnt = 0;
        end
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- write-back monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb_on && mem_wb_regwrite) begin
        if (exp_q.size() == 0) chk("wb_unexpected", 64'(mem_wb_regwrite), 64'd0);
        else chk("wb_retire", 64'({mem_wb_desreg, mem_wb_data3}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int            stalls;
    int            k, w;
    logic          v, rw, mr, mw, mtr;
    logic [DW-1:0] a, rt, ld;
    logic [RW-1:0] rd;

    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_exm_data", 64'(ex_mem_data3), 64'd0);
    chk("rst_wb_rw", 64'(mem_wb_regwrite), 64'd0);
    chk("rst_err", 64'(bus_err), 64'd0);
    rst = 1'b0;

    // non-memory instruction: add -> r5 = 0x10
    set_ex(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("alu_exm_data", 64'(ex_mem_data3), 64'h10);
    chk("alu_exm_rd", 64'(ex_mem_desreg), 64'd5);
    chk("alu_exm_rw", 64'(ex_mem_regwrite), 64'd1);
    chk("alu_stall", 64'(mem_stall), 64'd0);
    bubble();
    step();
    chk("alu_wb_data", 64'(mem_wb_data3), 64'h10);
    chk("alu_wb_rd", 64'(mem_wb_desreg), 64'd5);
    chk("alu_wb_rw", 64'(mem_wb_regwrite), 64'd1);
    chk("alu_stall2", 64'(mem_stall), 64'd0);

    // zero-wait load from 0x100
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    set_ex(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("ld0_req", 64'(dmem_req), 64'd1);
    chk("ld0_we", 64'(dmem_we), 64'd0);
    chk("ld0_addr", 64'(dmem_addr), 64'h100);
    chk("ld0_stall", 64'(mem_stall), 64'd0);
    bubble();
    step();
    chk("ld0_wb_data", 64'(mem_wb_data3), 64'hCAFE_F00D);
    chk("ld0_wb_rd", 64'(mem_wb_desreg), 64'd7);
    chk("ld0_wb_rw", 64'(mem_wb_regwrite), 64'd1);
    chk("ld0_req_drop", 64'(dmem_req), 64'd0);
    dmem_ack = 1'b0;

    // store to 0x204 with three wait cycles; ack on the 4th request cycle
    set_ex(1'b1, 32'h204, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_ex(1'b1, 32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    stalls = 0;
    for (int c = 1; c <= 4; c++) begin
      dmem_ack = (c == 4);
      #1;
      chk("st_req", 64'(dmem_req), 64'd1);
      chk("st_we", 64'(dmem_we), 64'd1);
      chk("st_addr", 64'(dmem_addr), 64'h204);
      chk("st_wdata", 64'(dmem_wdata), 64'h1234_5678);
      chk("st_exm_hold", 64'(ex_mem_data3), 64'h204);
      if (mem_stall) stalls++;
      step();
    end
    dmem_ack = 1'b0;
    chk("st_stall_cycles", 64'(stalls), 64'd3);
    chk("st_wb_rw", 64'(mem_wb_regwrite), 64'd0);
    chk("st_next_exm", 64'(ex_mem_data3), 64'h55);
    bubble();
    step();
    chk("st_next_wb_data", 64'(mem_wb_data3), 64'h55);
    chk("st_next_wb_rw", 64'(mem_wb_regwrite), 64'd1);
    chk("no_err_yet", 64'(bus_err), 64'd0);

    // timeout: load at 0x300, ack never comes
    set_ex(1'b1, 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_ex(1'b1, 32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      chk("to_req", 64'(dmem_req), 64'(c <= 4));
      chk("to_stall", 64'(mem_stall), 64'(c <= 4));
      chk("to_wb_rw", 64'(mem_wb_regwrite), 64'd0);
      if (c == 5) chk("to_state", 64'(dbg_state), 64'(S_ABORT));
      step();
    end
    chk("to_err", 64'(bus_err), 64'd1);
    chk("to_wb_rw_after", 64'(mem_wb_regwrite), 64'd0);
    chk("to_resume_exm", 64'(ex_mem_data3), 64'h77);
    bubble();
    step();
    chk("to_resume_wb", 64'(mem_wb_data3), 64'h77);
    chk("to_resume_wb_rw", 64'(mem_wb_regwrite), 64'd1);

    // reset in the second cycle of a pending load
    set_ex(1'b1, 32'h180, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    bubble();
    step();
    chk("rw_pending_req", 64'(dmem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("rw_req_drop", 64'(dmem_req), 64'd0);
    chk("rw_stall_drop", 64'(mem_stall), 64'd0);
    chk("rw_exm_data", 64'(ex_mem_data3), 64'd0);
    chk("rw_wb_data", 64'(mem_wb_data3), 64'd0);
    chk("rw_wb_rw", 64'(mem_wb_regwrite), 64'd0);
    chk("rw_err_clr", 64'(bus_err), 64'd0);
    chk("rw_state", 64'(dbg_state), 64'(S_IDLE));
    step();
    rst = 1'b0;
    dmem_rdata = 32'hDEAD_BEEF;
    set_ex(1'b1, 32'h180, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("rw_new_stall", 64'(mem_stall), 64'd1);
    dmem_ack = 1'b1;
    #1;
    chk("rw_new_release", 64'(mem_stall), 64'd0);
    bubble();
    step();
    dmem_ack = 1'b0;
    chk("rw_new_wb_data", 64'(mem_wb_data3), 64'hDEAD_BEEF);
    chk("rw_new_wb_rw", 64'(mem_wb_regwrite), 64'd1);

    // misaligned load at 0x102
    set_ex(1'b1, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_stall", 64'(mem_stall), 64'd0);
    bubble();
    step();
    chk("mis_err", 64'(bus_err), 64'd1);
    chk("mis_wb_rw", 64'(mem_wb_regwrite), 64'd0);

    // random stream against the transaction-level model
    rst = 1'b1;
    step();
    rst = 1'b0;
    auto_resp = 1'b1;
    sb_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 9);
      v   = ($urandom_range(0, 7) != 0);
      rd  = RW'($urandom);
      rt  = $urandom;
      w   = $urandom_range(0, TO + 1);
      if (k < 4) begin
        a = $urandom; rw = 1'($urandom_range(0, 1)); mr = 1'b0; mw = 1'b0; mtr = 1'b0;
      end else begin
        a = 32'h400 + (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        mr = (k < 7); mw = ~mr; mtr = mr; rw = mr;
      end
      if (v) begin
        if (mr || mw) begin
          if (a[1:0] != 2'b00) exp_err = 1'b1;
          else begin
            wait_q.push_back(w);
            if (w >= TO) exp_err = 1'b1;
            else if (mw) model_mem[a] = rt;
            else if (rw) begin
              ld = model_mem.exists(a) ? model_mem[a] : mem_default(a);
              exp_q.push_back({rd, ld});
            end
          end
        end else if (rw) begin
          exp_q.push_back({rd, a});
        end
      end
      issue(v, a, rt, rd, rw, mr, mw, mtr);
    end
    bubble();
    repeat (10) step();
    chk("rand_wb_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_req_drained", 64'(wait_q.size()), 64'd0);
    chk("rand_bus_err", 64'(bus_err), 64'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the EX-stage ALU.
- Holds the EX/MEM pipeline register and drives a single-outstanding data-memory request/acknowledge interface.
- Holds the MEM/WB pipeline register.
- Supplies the two forwarding values the ALU consumes (EX_MEM_data3, MEM_WB_data3), and stalls upstream while a memory access is pending.

Parameters:
- DATA_W, 32, datapath and memory data width.
- REG_W, 5, destination-register index width.
- TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting (range 2..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble).
- ex_aluresult  in  DATA_W  ALU result; byte address for loads/stores.
- ex_rtresult  in  DATA_W  forwarded rt value; store data.
- ex_desreg  in  REG_W  destination register.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  in  1 each  control bits from ID/EX.
- mem_stall  out  1  freeze PC, IF/ID and ID/EX; EX/MEM holds its contents.
- ex_mem_data3  out  DATA_W  EX/MEM ALU result; forwarding source.
- ex_mem_desreg  out  REG_W  EX/MEM destination register.
- ex_mem_regwrite  out  1  EX/MEM register-write bit, for the forwarding unit.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DATA_W  byte address, word aligned.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack.
- dmem_ack  in  1  request completes this cycle.
- mem_wb_data3  out  DATA_W  write-back value: memtoreg ? rdata : aluresult.
- mem_wb_desreg  out  REG_W  write-back destination register.
- mem_wb_regwrite  out  1  write-back enable.
- bus_err  out  1  sticky error flag (timeout or misaligned access).

Behaviour:
- Reset (async, immediate):
  - All EX/MEM and MEM/WB fields clear to 0; FSM goes to IDLE; wait counter and bus_err clear to 0.
  - dmem_req, mem_stall and every other output read 0 while rst is high. A request in flight is dropped with no completion.
- EX/MEM capture:
  - Loads on the rising edge when mem_stall=0.
  - If ex_valid=0, loads a bubble: regwrite, memread and memwrite all 0.
- Memory op definition: memop = exm_memread | exm_memwrite. Misaligned means exm_aluresult[1:0] != 0.
- Memory port drive:
  - dmem_addr = exm_aluresult; dmem_wdata = exm_rtresult; dmem_we = exm_memwrite.
  - dmem_req = memop & aligned & state!=ABORT.
  - Address, data and we stay stable for as long as req is held.
- FSM states: IDLE, WAIT, ABORT.
  - IDLE, aligned memop, ack=1: zero-wait completion. No stall; MEM/WB captures on this edge.
  - IDLE, aligned memop, ack=0: go to WAIT and set counter to 1.
  - WAIT, ack=1: completes and returns to IDLE.
  - WAIT, ack=0, counter=TIMEOUT-1: go to ABORT. Otherwise counter increments.
  - ABORT: lasts one cycle, req=0, op retires as a bubble, bus_err set, then IDLE.
  - Misaligned memop: no request and no stall; retires in one cycle as a bubble and sets bus_err.
- Stall: mem_stall = aligned memop & !dmem_ack & state!=ABORT.
- MEM/WB capture, every edge:
  - If the EX/MEM op is completing (no stall, not aborted, not misaligned): register-write bit = exm_regwrite, destination = exm_desreg, data3 = exm_memtoreg ? dmem_rdata : exm_aluresult.
  - Otherwise MEM/WB captures a bubble: regwrite=0, data3 and desreg held.
- Latency:
  - Non-memory instruction: 1 cycle EX→EX/MEM, 1 cycle EX/MEM→MEM/WB.
  - Load/store: 1 + number of wait cycles.
- Back-to-back memory ops: the next op enters EX/MEM on the same edge the previous one completes; its req asserts the following cycle.
- Store followed by a load to the same address needs no special handling; strict in-order, single outstanding.
- bus_err: cleared only by rst.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and REG_W constants.
  - A struct for the EX/MEM control bundle {regwrite, memread, memwrite, memtoreg}, reused by the ID/EX and forwarding units.
  - The FSM state enum.
- One natural sub-module: mem_wait_timer. It contains the wait counter and timeout compare, with inputs start/ack and output expire.

Test Plan:
- Non-memory op: add with result 0x0000_0010, rd=5, regwrite=1.
  - Required: ex_mem_data3=0x10 after edge 1.
  - Required: mem_wb_data3=0x10, desreg=5, regwrite=1 after edge 2; mem_stall never asserted.
- Zero-wait load: addr 0x100, ack tied 1, rdata 0xCAFEF00D.
  - Required: dmem_req for 1 cycle with we=0, no stall; mem_wb_data3=0xCAFEF00D next edge.
- 3-wait store: addr 0x204, data 0x12345678, ack on 4th request cycle.
  - Required: mem_stall high for exactly 3 cycles; addr/wdata/we=1 stable throughout.
  - Required: the following instruction's EX values are held until release; store retires with regwrite=0.
- Timeout with TIMEOUT=4 and ack never asserted.
  - Required: req high for 4 cycles, then 1 ABORT cycle with req=0.
  - Required: bus_err=1; MEM/WB regwrite stays 0; pipeline resumes.
- Misaligned load at 0x102.
  - Required: no dmem_req, no stall, bus_err=1, MEM/WB regwrite=0.
- Reset mid-wait: assert rst in cycle 2 of a pending load.
  - Required: dmem_req and mem_stall drop immediately (same cycle), all outputs 0.
  - Required: after release, a new load completes normally.
